// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the multiply/divide unit
//
// Purpose: op codes, FSM state encoding and fixed result constants used by
// mult_div_unit and its testbench.
// Ports: none (package).

package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    // Quotient reported for any divide by zero, signed or unsigned.
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // Counter load value: 32 iterations counted 31 down to 0.
    localparam logic [4:0] ITER_LAST = 5'd31;

    // True for ops that run through CALC/FIX.
    function automatic logic is_iter_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // True for ops whose operands are interpreted as two's complement.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// rtl/mult_div_unit_sign_fix.sv - conditional two's-complement negate
//
// Purpose: result = negate ? -value : value, purely combinational. Used both to
// take operand magnitudes and to restore result signs.
// Ports:
//   value  in  W : input word
//   negate in  1 : negate when high
//   result out W : value or its two's complement

module sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit owning HI and LO
//
// Purpose: executes MULT/MULTU/DIV/DIVU in 32 iterations (one bit per edge)
// plus one sign fix-up edge, and MTHI/MTLO in a single edge.
// Ports:
//   clk      in  1      : clock, all state changes on the rising edge
//   rst      in  1      : synchronous active-high reset, aborts any op
//   start    in  1      : request strobe, accepted only while idle
//   op       in  3      : operation code (mdu_pkg::op_e)
//   rs_data  in  DATA_W : dividend / multiplicand / MTHI-MTLO source
//   rt_data  in  DATA_W : divisor / multiplier
//   busy     out 1      : iterative op in flight
//   done     out 1      : one-cycle pulse when HI/LO take a MULT/DIV result
//   hi       out DATA_W : HI register
//   lo       out DATA_W : LO register

module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int ACC_W = 2 * DATA_W;

    state_e              state;
    state_e              state_nxt;
    logic [4:0]          cnt;
    logic [ACC_W-1:0]    acc;       // multiply: {partial product, multiplier}; divide: {remainder, quotient}
    logic [DATA_W-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [DATA_W-1:0]   rs_raw;    // untouched dividend, reported as HI on divide by zero
    logic                is_div;
    logic                div_zero;
    logic                neg_q;     // negate product / quotient
    logic                neg_r;     // negate remainder
    logic                in_fix;

    logic                idle_start;
    logic                neg_rs_in;
    logic                neg_rt_in;
    logic [DATA_W-1:0]   rs_mag;
    logic [DATA_W-1:0]   rt_mag;

    logic [DATA_W:0]     mul_sum;
    logic [ACC_W-1:0]    mul_next;
    logic [DATA_W:0]     div_top;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [ACC_W-1:0]    div_next;

    logic [ACC_W-1:0]    res_fixed;
    logic [DATA_W-1:0]   rem_fixed;

    // ------------------------------------------------------------------
    // Operand magnitudes
    // ------------------------------------------------------------------
    assign idle_start = start && (state == ST_IDLE);
    assign neg_rs_in  = is_signed_op(op) && rs_data[DATA_W-1];
    assign neg_rt_in  = is_signed_op(op) && rt_data[DATA_W-1];

    sign_fix #(.W(DATA_W)) u_rs_mag (.value(rs_data), .negate(neg_rs_in), .result(rs_mag));
    sign_fix #(.W(DATA_W)) u_rt_mag (.value(rt_data), .negate(neg_rt_in), .result(rt_mag));

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right;
    // the carry out of the add becomes the new MSB.
    assign mul_sum  = {1'b0, acc[ACC_W-1:DATA_W]} + {1'b0, opnd};
    assign mul_next = acc[0] ? {mul_sum, acc[DATA_W-1:1]}
                             : {1'b0, acc[ACC_W-1:DATA_W], acc[DATA_W-1:1]};

    // Restoring divide: the shifted remainder needs 33 bits because it can
    // reach twice a divisor that is itself close to 2^32.
    assign div_top  = acc[ACC_W-1:DATA_W-1];
    assign div_diff = div_top - {1'b0, opnd};
    assign div_ge   = (div_top >= {1'b0, opnd});
    assign div_next = {(div_ge ? div_diff[DATA_W-1:0] : div_top[DATA_W-1:0]),
                       acc[DATA_W-2:0], div_ge};

    // ------------------------------------------------------------------
    // Result sign fix-up. The low half of a 64-bit negate equals the 32-bit
    // negate of the low half, so the product fixer also yields the quotient.
    // ------------------------------------------------------------------
    sign_fix #(.W(ACC_W))  u_res_fix (.value(acc), .negate(neg_q), .result(res_fixed));
    sign_fix #(.W(DATA_W)) u_rem_fix (.value(acc[ACC_W-1:DATA_W]), .negate(neg_r), .result(rem_fixed));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start && is_iter_op(op)) state_nxt = ST_CALC;
            ST_CALC: if (cnt == 5'd0)             state_nxt = ST_FIX;
            ST_FIX:                               state_nxt = ST_IDLE;
            default:                              state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state != ST_IDLE);
        in_fix = (state == ST_FIX);
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 5'd0;
            acc      <= '0;
            opnd     <= '0;
            rs_raw   <= '0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= in_fix;
            if (idle_start) begin
                case (op)
                    OP_MTHI: hi <= rs_data;
                    OP_MTLO: lo <= rs_data;
                    OP_MULT, OP_MULTU: begin
                        acc    <= {{DATA_W{1'b0}}, rt_mag};
                        opnd   <= rs_mag;
                        is_div <= 1'b0;
                        neg_q  <= neg_rs_in ^ neg_rt_in;
                        neg_r  <= 1'b0;
                        cnt    <= ITER_LAST;
                    end
                    OP_DIV, OP_DIVU: begin
                        acc      <= {{DATA_W{1'b0}}, rs_mag};
                        opnd     <= rt_mag;
                        rs_raw   <= rs_data;
                        div_zero <= (rt_data == '0);
                        is_div   <= 1'b1;
                        neg_q    <= neg_rs_in ^ neg_rt_in;
                        neg_r    <= neg_rs_in;
                        cnt      <= ITER_LAST;
                    end
                    default: ;
                endcase
            end else if (state == ST_CALC) begin
                acc <= is_div ? div_next : mul_next;
                if (cnt != 5'd0) begin
                    cnt <= cnt - 5'd1;
                end
            end else if (in_fix) begin
                if (!is_div) begin
                    hi <= res_fixed[ACC_W-1:DATA_W];
                    lo <= res_fixed[DATA_W-1:0];
                end else if (div_zero) begin
                    hi <= rs_raw;
                    lo <= DIV0_QUOT;
                end else begin
                    hi <= rem_fixed;
                    lo <= res_fixed[DATA_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit

module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;

    always #5 clk = ~clk;

    mult_div_unit #(.DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Architectural reference: MIPS HI/LO semantics in plain arithmetic.
    task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sp;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin sp = sa * sb; up = sp; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            3'd1: begin up = {32'h0, a} * {32'h0, b}; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            3'd2, 3'd3: begin
                if (b == 32'h0) begin
                    exp_hi = a;
                    exp_lo = 32'hFFFF_FFFF;
                end else if (o == 3'd2) begin
                    sp = sa / sb; up = sp; exp_lo = up[31:0];
                    sp = sa % sb; up = sp; exp_hi = up[31:0];
                end else begin
                    exp_lo = a / b;
                    exp_hi = a % b;
                end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Iterative op: called at a negedge; start is accepted at the next edge (E0).
    // mid_start >= 0 re-asserts start at that busy sample, which must be ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int mid_start);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int busy_cnt;
        int early_done;
        int bad_hold;
        old_hi = exp_hi;
        old_lo = exp_lo;
        busy_cnt = 0;
        early_done = 0;
        bad_hold = 0;
        ref_op(o, a, b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rs_data = $urandom;
        rt_data = $urandom;
        for (int k = 0; k < 33; k++) begin
            if (k > 0) @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b0) early_done++;
            if (hi !== old_hi || lo !== old_lo) bad_hold++;
            if (k == mid_start) begin
                op = OP_DIVU; rs_data = 32'd100; rt_data = 32'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, ".busy_cycles"}, busy_cnt, 33);
        check({tag, ".early_done"}, early_done, 0);
        check({tag, ".hilo_hold"}, bad_hold, 0);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".busy_end"}, busy, 1'b0);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
    endtask

    // Single-edge op (MTHI/MTLO/invalid): called at a negedge.
    task automatic quick_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b);
        ref_op(o, a, b);
        op = o; rs_data = a; rt_data = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy"}, busy, 1'b0);
        check({tag, ".done"}, done, 1'b0);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        int          done_seen;
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;

        rst = 1'b1; start = 1'b0; op = 3'd0; rs_data = 32'h0; rt_data = 32'h0;
        repeat (3) @(negedge clk);
        check("reset.busy", busy, 1'b0);
        check("reset.done", done, 1'b0);
        check("reset.hi", hi, 32'h0);
        check("reset.lo", lo, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, -1);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, -1);
        run_op("divu_zero", OP_DIVU, 32'h1234_5678, 32'h0, -1);
        run_op("div_zero_signed", OP_DIV, 32'h8765_4321, 32'h0, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op("div_neg_divisor", OP_DIV, 32'd100, 32'hFFFF_FFF9, -1);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, -1);

        quick_op("mthi", OP_MTHI, 32'hDEAD_BEEF, 32'h0);
        run_op("mult_midstart", OP_MULT, 32'd5, 32'd6, 10);
        quick_op("mtlo", OP_MTLO, 32'hCAFE_F00D, 32'h0);
        quick_op("invalid6", 3'd6, 32'h1111_1111, 32'h2222_2222);
        quick_op("invalid7", 3'd7, 32'h3333_3333, 32'h4444_4444);

        // Reset mid-operation: accept at E0, reset sampled at E10.
        op = OP_MULT; rs_data = 32'd5; rt_data = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        check("rst_mid.busy", busy, 1'b0);
        check("rst_mid.hi", hi, 32'h0);
        check("rst_mid.lo", lo, 32'h0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) done_seen++;
        end
        check("rst_mid.no_done", done_seen, 0);
        run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, -1);

        for (int i = 0; i < 24; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'h0;
                1:       r_b = 32'($urandom_range(1, 20));
                2:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
                default: r_b = $urandom;
            endcase
            if (r_op <= 3'd3) run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, -1);
            else              quick_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b);
        end

        @(negedge clk);
        check("final.done_low", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit of the MIPS datapath, owning the HI and LO registers. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode/execute stage. It runs multiply and divide over 32 iterations while the controller stalls on `busy`. It drives `hi`/`lo` into the register write-back 3-to-1 selector, which uses them for MFHI/MFLO results.

## Interface
- `DATA_W`, default 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: request strobe, sampled on the rising edge.
- `op`  in  3: operation code (see package).
- `rs_data`  in  32: dividend / multiplicand / MTHI-MTLO source.
- `rt_data`  in  32: divisor / multiplier.
- `busy`  out  1: high while an iterative operation is in flight.
- `done`  out  1: one-cycle pulse when HI/LO take a MULT/DIV result.
- `hi`  out  32: HI register, to the write-back selector.
- `lo`  out  32: LO register, to the write-back selector.

## Operation
- **State machine:** IDLE, CALC, FIX. `busy` = (state != IDLE).
- **Accept:** a request is accepted on an edge where `start`=1 and state=IDLE. If `start`=1 while `busy`=1, the request is ignored: no queuing and no error.
- **MTHI / MTLO:** written in the accepting edge. HI or LO is set to `rs_data`; the other register is unchanged. No `busy`, no `done`, state stays IDLE.
- **Operand latch:** MULT/MULTU/DIV/DIVU latch operands at accept. Signed ops convert the operands to magnitudes and record the result signs:
  - Product sign = sign(rs) xor sign(rt).
  - Remainder sign = sign(rs).
- **Loading:** 5-bit iteration counter is loaded with 31 and state goes to CALC.
- **CALC multiply:** shift-add over a 64-bit accumulator, one multiplier bit per edge, LSB first.
- **CALC divide:** restoring division over a 64-bit {remainder, quotient} register, one quotient bit per edge.
- **CALC exit:** after 32 edges (counter reaches 0) go to FIX.
- **FIX:** apply two's-complement negation per the recorded signs, then:
  - MULT*: HI = product[63:32], LO = product[31:0].
  - DIV*: LO = quotient, HI = remainder.
  - Pulse `done`, return to IDLE.
- **Divide by zero** (rt=0), fixed behaviour: LO = 0xFFFFFFFF, HI = rs_data. This is the unsigned and signed result alike; no sign fix is applied. The op still takes the full latency.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This is the natural 32-bit wrap.
- **Outputs during an op:** HI/LO hold their old values until the FIX edge, so MFHI/MFLO reads before completion return the old values.
- **Invalid `op` codes:** accepted as a no-op; no state change.
- **Reset:** `rst` has priority over everything. Any operation in flight is aborted.

## Timing
- **Reset values:** state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.
- **Accept at edge E0:** `busy`=1 from after E0. Iterations run on E1..E32, FIX occurs at E33.
- **Completion:** after E33, `hi`/`lo` are valid, `busy`=0, and `done`=1 for exactly one cycle. Latency is 33 cycles from accept to result.
- **Back-to-back:** a new request may be accepted on E34, the first edge with `busy`=0. The `done` cycle and the accept edge may coincide.
- **MTHI/MTLO:** the value is visible the cycle after the accepting edge. Latency 1, `busy` never asserted.
- **Reset mid-op:** `rst`=1 at any edge during CALC/FIX returns the block to reset values after that edge. No `done` pulse.

## Structure
- **Package `mdu_pkg`:**
  - Op encodings: MULT=3'd0, MULTU=3'd1, DIV=3'd2, DIVU=3'd3, MTHI=3'd4, MTLO=3'd5.
  - State encoding: IDLE=2'd0, CALC=2'd1, FIX=2'd2.
  - `DIV0_QUOT` = 32'hFFFFFFFF.
- **Sub-module `sign_fix`:** combinational conditional two's-complement negate, 32 or 64 bits by parameter. Instantiated for operand magnitudes and for result fix-up.

## Test plan
- MULT: rs=0xFFFFFFFE (−2), rt=3 → after 33 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFFA, `done` pulses once, `busy` high for exactly 33 cycles.
- MULTU: rs=0xFFFFFFFF, rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV: rs=−7 (0xFFFFFFF9), rt=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- DIVU by zero: rs=0x12345678, rt=0 → LO=0xFFFFFFFF, HI=0x12345678, still 33 cycles.
- MTHI of 0xDEADBEEF, then MULT 5×6 with `start` re-asserted mid-op (ignored) → HI=0xDEADBEEF until the FIX edge, then HI=0 and LO=30. The second `start` has no effect.
- MULT 5×6, `rst` asserted at E10 → HI=LO=0, `busy`=0, no `done`. A new DIVU 100/7 then yields LO=14, HI=2.
